// File: rtl/vmem_pkg.sv
// Shared types and defaults for the vector memory-stage sequencer.
// FSM state encodings, default widths and small address/index helpers.
package vmem_pkg;

    localparam int VMEM_WORD_W   = 32;
    localparam int VMEM_LANES    = 4;
    localparam int VMEM_ADDR_INC = 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_VST      = 2'd1;
    localparam state_t ST_VLD      = 2'd2;
    localparam state_t ST_VLD_LAST = 2'd3;

    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Modulo-2^32 address of a given lane.
    function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                              input logic [31:0] idx,
                                              input logic [31:0] inc);
        return base + idx * inc;
    endfunction

endpackage

// File: rtl/vmem_lane_collect.sv
// Gathers successive RAM read words into one vector result.
// The last lane is merged straight from mem_q so the result is usable in the retiring cycle.
module vmem_lane_collect
    import vmem_pkg::*;
#(
    parameter int WORD_W = VMEM_WORD_W,
    parameter int LANES  = VMEM_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    capture,
    input  logic                    done,
    input  logic [WORD_W-1:0]       mem_q,
    output logic                    last_lane,
    output logic [WORD_W*LANES-1:0] vec
);

    localparam int LW = lane_idx_w(LANES);

    logic [LW-1:0]           lane_cnt_reg;
    logic [WORD_W-1:0]       lane_reg [LANES-1];
    logic [WORD_W*LANES-1:0] assembled;
    logic [WORD_W*LANES-1:0] vec_reg;

    assign last_lane = capture && (lane_cnt_reg == LW'(LANES - 2));

    generate
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
            assign assembled[gi*WORD_W +: WORD_W] = lane_reg[gi];
        end
    endgenerate
    assign assembled[(LANES-1)*WORD_W +: WORD_W] = mem_q;

    // New words enter at the top and walk down, so lane 0 ends up lowest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_cnt_reg <= '0;
            for (int i = 0; i < LANES - 1; i++) lane_reg[i] <= '0;
            vec_reg <= '0;
        end else begin
            if (start) begin
                lane_cnt_reg <= '0;
            end else if (capture) begin
                lane_cnt_reg <= lane_cnt_reg + LW'(1);
                for (int i = 0; i < LANES - 2; i++) lane_reg[i] <= lane_reg[i+1];
                lane_reg[LANES-2] <= mem_q;
            end
            if (done) vec_reg <= assembled;
        end
    end

    assign vec = done ? assembled : vec_reg;

endmodule

// File: rtl/vmem_sequencer.sv
// Memory-stage controller: scalar and multi-beat vector loads/stores on a 32-bit RAM.
// Optional stall-cycle counter enabled by defining VMEM_STALL_CNT_EN.
module vmem_sequencer
    import vmem_pkg::*;
#(
    parameter int WORD_W   = VMEM_WORD_W,
    parameter int LANES    = VMEM_LANES,
    parameter int ADDR_INC = VMEM_ADDR_INC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memw_M,
    input  logic                    regmem_M,
    input  logic                    vec_M,
    input  logic [31:0]             address_M,
    input  logic [WORD_W-1:0]       ALUrslt_M,
    input  logic [WORD_W*LANES-1:0] regrsltV_M,
    output logic [31:0]             mem_addr,
    output logic [WORD_W-1:0]       mem_data,
    output logic                    mem_wren,
    input  logic [WORD_W-1:0]       mem_q,
    output logic                    stall,
    output logic                    ld_valid,
    output logic [WORD_W-1:0]       ld_data,
    output logic [WORD_W*LANES-1:0] ld_dataV,
    output logic [31:0]             stall_cnt
);

    localparam int             VEC_W     = WORD_W * LANES;
    localparam int             LW        = lane_idx_w(LANES);
    localparam logic [LW-1:0]  LAST_BEAT = LW'(LANES - 1);

    state_t            state_reg, state_next;
    logic [LW-1:0]     beat_reg, beat_next;
    logic [31:0]       base_reg;
    logic [VEC_W-1:0]  data_reg;
    logic              sld_reg, sld_next;
    logic [WORD_W-1:0] ld_data_reg;
    logic [31:0]       beat_addr;
    logic [WORD_W-1:0] beat_word;
    logic              accept, vld_start, capture, done, last_lane;

    assign beat_addr = lane_addr(base_reg, 32'(beat_reg), 32'(ADDR_INC));
    assign beat_word = data_reg[int'(beat_reg)*WORD_W +: WORD_W];

    // Beat 0 of every op is driven straight from EX/MEM; later beats come from latched copies.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        mem_addr   = '0;
        mem_data   = '0;
        mem_wren   = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;
        vld_start  = 1'b0;
        capture    = 1'b0;
        done       = 1'b0;
        sld_next   = 1'b0;
        if (rst) begin
            case (state_reg)
                ST_IDLE: begin
                    beat_next = LW'(1);
                    if (memw_M) begin
                        accept   = 1'b1;
                        mem_addr = address_M;
                        mem_wren = 1'b1;
                        if (vec_M) begin
                            mem_data   = regrsltV_M[WORD_W-1:0];
                            stall      = 1'b1;
                            state_next = ST_VST;
                        end else begin
                            mem_data = ALUrslt_M;
                        end
                    end else if (regmem_M) begin
                        accept   = 1'b1;
                        mem_addr = address_M;
                        if (vec_M) begin
                            stall      = 1'b1;
                            vld_start  = 1'b1;
                            state_next = ST_VLD;
                        end else begin
                            sld_next = 1'b1;
                        end
                    end
                end
                ST_VST: begin
                    mem_addr = beat_addr;
                    mem_data = beat_word;
                    mem_wren = 1'b1;
                    stall    = (beat_reg != LAST_BEAT);
                    if (beat_reg == LAST_BEAT) state_next = ST_IDLE;
                    else                       beat_next  = beat_reg + LW'(1);
                end
                ST_VLD: begin
                    mem_addr  = beat_addr;
                    stall     = 1'b1;
                    capture   = 1'b1;
                    beat_next = beat_reg + LW'(1);
                    if (last_lane) state_next = ST_VLD_LAST;
                end
                default: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            beat_reg    <= '0;
            base_reg    <= '0;
            data_reg    <= '0;
            sld_reg     <= 1'b0;
            ld_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            sld_reg   <= sld_next;
            if (accept) begin
                base_reg <= address_M;
                data_reg <= regrsltV_M;
            end
            if (sld_reg) ld_data_reg <= mem_q;
        end
    end

    assign ld_valid = rst & (sld_reg | done);
    assign ld_data  = (rst & sld_reg) ? mem_q : ld_data_reg;

    vmem_lane_collect #(
        .WORD_W (WORD_W),
        .LANES  (LANES)
    ) u_collect (
        .clk       (clk),
        .rst       (rst),
        .start     (vld_start),
        .capture   (capture),
        .done      (done),
        .mem_q     (mem_q),
        .last_lane (last_lane),
        .vec       (ld_dataV)
    );

`ifdef VMEM_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst)                              stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt = stall_cnt_reg;
`else
    assign stall_cnt = '0;
`endif

endmodule
